// File: rtl/m_seg7_scan.sv
// Four-digit common-anode 7-segment scanner: latches a 16-bit hex value once
// per frame and multiplexes it with a blank dead-time cycle ahead of each digit.
module m_seg7_scan #(
  parameter int unsigned PRESCALE = 4,
  parameter logic        LZ_BLANK = 1'b1
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_en,
  input  logic [15:0] w_din,
  output logic [3:0]  r_an,
  output logic [6:0]  r_seg,
  output logic        r_frame,
  output logic [1:0]  r_digit
);

  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] val_q, val_d;

  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        frame_d;
  logic [1:0]  digit_out_d;

  logic [3:0]  nibble;
  logic        lead_zero;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencer; the display value is only taken on the GAP->SHOW edge of digit 0.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    presc_d = presc_q;
    val_d   = val_q;
    if (!w_en) begin
      state_d = ST_GAP;
      digit_d = 2'd0;
      presc_d = 8'd0;
    end else begin
      case (state_q)
        ST_GAP: begin
          state_d = ST_SHOW;
          presc_d = 8'd0;
          if (digit_q == 2'd0) begin
            val_d = w_din;
          end
        end
        ST_SHOW: begin
          if (presc_q == PS_LAST) begin
            state_d = ST_GAP;
            digit_d = digit_q + 2'd1;
            presc_d = 8'd0;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_GAP;
          digit_d = 2'd0;
          presc_d = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    nibble    = 4'h0;
    lead_zero = 1'b0;
    case (digit_q)
      2'd0: nibble = val_q[3:0];
      2'd1: begin
        nibble    = val_q[7:4];
        lead_zero = (val_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble    = val_q[11:8];
        lead_zero = (val_q[15:8] == 8'h00);
      end
      default: begin
        nibble    = val_q[15:12];
        lead_zero = (val_q[15:12] == 4'h0);
      end
    endcase
  end

  // Outputs are a registered image of the current sequencer state.
  always_comb begin
    an_d        = 4'b1111;
    seg_d       = 7'h7F;
    frame_d     = 1'b0;
    digit_out_d = digit_q;
    if (!w_en) begin
      digit_out_d = 2'd0;
    end else begin
      case (state_q)
        ST_GAP: begin
          frame_d = (digit_q == 2'd0);
        end
        ST_SHOW: begin
          an_d  = ~(4'b0001 << digit_q);
          seg_d = (LZ_BLANK && lead_zero) ? 7'h7F : seg7_decode(nibble);
        end
        default: begin
          digit_out_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= ST_GAP;
      digit_q <= 2'd0;
      presc_q <= 8'd0;
      val_q   <= 16'h0000;
      r_an    <= 4'b1111;
      r_seg   <= 7'h7F;
      r_frame <= 1'b0;
      r_digit <= 2'd0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      presc_q <= presc_d;
      val_q   <= val_d;
      r_an    <= an_d;
      r_seg   <= seg_d;
      r_frame <= frame_d;
      r_digit <= digit_out_d;
    end
  end

endmodule

// File: tb/tb_m_seg7_scan.sv
// Bench for m_seg7_scan: two instances (default and PRESCALE=2 without
// leading-zero blanking) checked every cycle against a frame-position model.
module tb_m_seg7_scan;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        w_en;
  logic [15:0] w_din;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       frame_a, frame_b;
  logic [1:0] digit_a, digit_b;

  always #5 w_clk = ~w_clk;

  m_seg7_scan #(.PRESCALE(4), .LZ_BLANK(1'b1)) dut_a (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .w_din(w_din),
    .r_an(an_a), .r_seg(seg_a), .r_frame(frame_a), .r_digit(digit_a)
  );

  m_seg7_scan #(.PRESCALE(2), .LZ_BLANK(1'b0)) dut_b (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .w_din(w_din),
    .r_an(an_b), .r_seg(seg_b), .r_frame(frame_b), .r_digit(digit_b)
  );

  // Expected word layout: {an[3:0], seg[6:0], frame, digit[1:0]}
  logic [13:0] exp_a_q[$];
  logic [13:0] exp_b_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          pos_a = 0, pos_b = 0;
  logic [15:0] val_a = 16'h0, val_b = 16'h0;

  // pos = sequencer position within the frame while the current cycle runs;
  // the output after the edge reflects that position.
  task automatic model_step(input int ps, input logic lz, input logic rst, input logic en,
                            input logic [15:0] din, inout int pos, inout logic [15:0] val,
                            output logic [13:0] exp);
    int         period;
    int         d;
    int         k;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [3:0] an;
    logic [15:0] upper;
    period = 4 * (ps + 1);
    exp = {4'hF, 7'h7F, 1'b0, 2'd0};
    if (rst) begin
      val = 16'h0;
      pos = 0;
    end else if (!en) begin
      pos = 0;
    end else begin
      d = pos / (ps + 1);
      k = pos % (ps + 1);
      if (k == 0) begin
        exp = {4'hF, 7'h7F, (d == 0), 2'(d)};
      end else begin
        upper = val >> (4 * d);
        nib   = upper[3:0];
        seg   = seg_tab[nib];
        if (lz && d > 0 && upper == 16'h0) seg = 7'h7F;
        an    = 4'b1111;
        an[d] = 1'b0;
        exp   = {an, seg, 1'b0, 2'(d)};
      end
      if (pos == 0) val = din;
      pos = (pos + 1) % period;
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [15:0] d);
    logic [13:0] ea;
    logic [13:0] eb;
    w_rst = r;
    w_en  = e;
    w_din = d;
    @(posedge w_clk);
    model_step(4, 1'b1, r, e, d, pos_a, val_a, ea);
    model_step(2, 1'b0, r, e, d, pos_b, val_b, eb);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    #1;
  endtask

  task automatic run(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, d);
  endtask

  // Monitor: every cycle presents a valid output word on both instances.
  initial begin
    logic [13:0] act;
    logic [13:0] exp;
    forever begin
      @(posedge w_clk);
      #2;
      cyc++;
      act = {an_a, seg_a, frame_a, digit_a};
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL dut_a cycle %0d: output %h with no expected entry", cyc, act);
      end else begin
        exp = exp_a_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL dut_a cycle %0d: got an=%b seg=%h frame=%b digit=%0d, want an=%b seg=%h frame=%b digit=%0d",
                   cyc, act[13:10], act[9:3], act[2], act[1:0], exp[13:10], exp[9:3], exp[2], exp[1:0]);
        end
      end
      act = {an_b, seg_b, frame_b, digit_b};
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL dut_b cycle %0d: output %h with no expected entry", cyc, act);
      end else begin
        exp = exp_b_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL dut_b cycle %0d: got an=%b seg=%h frame=%b digit=%0d, want an=%b seg=%h frame=%b digit=%0d",
                   cyc, act[13:10], act[9:3], act[2], act[1:0], exp[13:10], exp[9:3], exp[2], exp[1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
    $fatal(1);
  end

  initial begin
    logic        r;
    logic        e;
    logic [15:0] d;
    // Reset held with all-ones input, then a frame of F,F,F,F
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'hFFFF);
    run(22, 16'hFFFF);
    // Scan timing over two frames
    cycle(1'b1, 1'b1, 16'h12AF);
    run(42, 16'h12AF);
    // Leading-zero patterns
    cycle(1'b1, 1'b1, 16'h0030);
    run(22, 16'h0030);
    cycle(1'b1, 1'b1, 16'h0000);
    run(22, 16'h0000);
    // Input changes mid-frame must not tear the display
    cycle(1'b1, 1'b1, 16'h1234);
    run(8, 16'h1234);
    run(34, 16'hABCD);
    // Enable dropped at the edge ending cycle 13, then restored
    cycle(1'b1, 1'b1, 16'h5A3C);
    run(13, 16'h5A3C);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h9999);
    run(25, 16'h9999);
    // Mid-frame reset at the cycle-12 edge
    cycle(1'b1, 1'b1, 16'h1234);
    run(12, 16'h1234);
    cycle(1'b1, 1'b1, 16'h1234);
    run(25, 16'h0005);
    // Randomized traffic
    d = 16'h0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 3));
      end
      cycle(r, e, d);
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
